multicycle_datapath: RTL
========================

// Module: multicycle_datapath
// PURPOSE
//  Parametrised multi-cycle RV32-style datapath, the successor to the single-cycle datapath.
//  Holds PC, IR, operand/result latches, a register file and the ALU, sequenced by an internal FSM.
//  Instruction and data memories are external and reached through req/ready handshakes, so wait states are tolerated.
//  The external controller decodes `instruction`. It drives the same control set as before, plus `pc_sel` for jumps and branches.
// PARAMETERS
//  XLEN     32  datapath and register width
//  NREGS    32  register count; x0 is hard-wired to zero
//  RESET_PC 0   PC value loaded on reset
//  PC_STEP  4   sequential PC increment
// PORTS
//  clk          in   1         clock
//  reset        in   1         synchronous, active-high reset
//  rg_wr_en     in   1         register write enable, acted on in WB
//  sel_a        in   1         ALU A operand: 0 = rs1, 1 = PC
//  sel_b        in   1         ALU B operand: 0 = rs2, 1 = imm_in
//  wb_sel       in   1         writeback source: 0 = ALU result, 1 = load data
//  rd_en        in   1         load access
//  wr_en        in   1         store access
//  rd_mask      in   3         load/store size mask, passed to dmem_mask
//  alu_op       in   4         ALU operation select
//  pc_sel       in   1         next PC: 0 = PC+PC_STEP, 1 = {alu_res[XLEN-1:1],1'b0}
//  imm_in       in   XLEN      sign-extended immediate from the external immediate generator
//  instruction  out  32        IR contents
//  pc_out       out  XLEN      current PC
//  state        out  3         FSM state: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4
//  imem_req     out  1         instruction fetch request
//  imem_addr    out  XLEN      fetch address (= pc_out)
//  imem_rdata   in   32        fetched word
//  imem_ready   in   1         fetch complete
//  dmem_req     out  1         data request
//  dmem_we      out  1         1 = store
//  dmem_addr    out  XLEN      data address
//  dmem_wdata   out  XLEN      store data
//  dmem_mask    out  3         size mask
//  dmem_rdata   in   XLEN      load data, already extended by the memory
//  dmem_ready   in   1         data access complete
//  cycle_cnt    out  64        cycle counter (optional feature)
//  instret_cnt  out  64        retired-instruction counter (optional feature)
// BEHAVIOUR
//  Reset (sync, top priority; aborts any state, including a pending handshake):
//   pc=RESET_PC, IR=0, all latches and registers = 0, state=FETCH.
//   Combinational outputs then follow FETCH, so imem_req=1 in the first cycle after reset.
//  FETCH:
//   imem_req=1, imem_addr=pc. Hold until imem_ready; then IR<=imem_rdata and go to DECODE.
//  DECODE:
//   A<=rf[rs1], B<=rf[rs2], with rs1=IR[19:15] and rs2=IR[24:20]. Go to EXEC.
//  EXEC:
//   R<=ALU(sel_a?pc:A, sel_b?imm_in:B).
//   Go to MEM if rd_en|wr_en, else go to WB.
//  MEM:
//   dmem_req=1, dmem_we=wr_en, dmem_addr=R, dmem_wdata=B, dmem_mask=rd_mask. All held stable until dmem_ready.
//   On dmem_ready with a load: MDR<=dmem_rdata. Then go to WB.
//   rd_en and wr_en both high: treated as a store, MDR unchanged.
//  WB:
//   If rg_wr_en and rd!=0 (rd=IR[11:7]): rf[rd]<=wb_sel?MDR:R.
//   pc<=pc_sel?{R[XLEN-1:1],1'b0}:pc+PC_STEP, modulo 2^XLEN (wraps silently).
//   Go to FETCH.
//  Outside their states, req/we are 0; addr/wdata/mask are don't-care but driven from the latches.
//  Control inputs are sampled only in the state that uses them. The controller keeps them stable from DECODE to WB.
//  ALU encoding:
//   0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B; 11-15 give 0.
//   Shift amount = B[$clog2(XLEN)-1:0]. SLT/SLTU produce 1 or 0, zero-extended.
//  Register file: 2 combinational reads, 1 synchronous write. Reads of x0 return 0.
//  Latency with zero-wait memory: 4 cycles (ALU instr), 5 cycles (load/store).
//   Each wait cycle on imem_ready or dmem_ready adds 1 cycle.
// CONFIGURATION
//  DP_PERF_CNT_EN defined:
//   cycle_cnt increments every non-reset cycle.
//   instret_cnt increments on each WB->FETCH transition.
//   Both are cleared by reset and wrap at 2^64.
//  DP_PERF_CNT_EN undefined: counters not built; cycle_cnt and instret_cnt are tied to 0. Ports always exist.
// TESTING
//  1. reset held 2 cycles, then released -> state=0, pc_out=RESET_PC, imem_req=1, imem_addr=0, dmem_req=0.
//  2. addi x1,x0,5 (0x00500093): imm_in=5, sel_b=1, alu_op=0, rg_wr_en=1, ready=1
//     -> x1=5 after 4 cycles, pc=4, state back to 0.
//  3. Write targeting x0, rg_wr_en=1, R=0x55 -> x0 still reads 0. Check with a store of x0: dmem_wdata=0.
//  4. Load with dmem_ready held low 3 cycles in MEM, dmem_rdata=0xDEADBEEF, wb_sel=1
//     -> dmem_req/addr stable for 4 cycles, rd receives 0xDEADBEEF, instruction takes 8 cycles.
//  5. jalr-style: pc_sel=1, ALU result 0x103 -> next pc=0x102.
//     Also: pc=0xFFFFFFFC with pc_sel=0 -> pc wraps to 0.
//  6. With DP_PERF_CNT_EN: 3 zero-wait ALU instructions after reset -> instret_cnt=3, cycle_cnt=12.
//     Reset asserted mid-MEM -> both counters 0, dmem_req=0, state=0 next cycle.

Source files
------------

// File: rtl/multicycle_datapath_if.sv
// Memory-side bus of the multi-cycle datapath: instruction fetch port and data port,
// each a req/ready handshake.
//   master : the datapath (drives requests, address, store data and size mask)
//   slave  : the memory system (returns fetched word, load data and ready strobes)
interface multicycle_datapath_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            imem_ready;

  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [2:0]      dmem_mask;
  logic [XLEN-1:0] dmem_rdata;
  logic            dmem_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata, imem_ready,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_mask,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata, imem_ready,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_mask,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/multicycle_datapath.sv
// Multi-cycle RV32-style datapath: PC, IR, A/B/R/MDR latches, register file and ALU,
// sequenced FETCH -> DECODE -> EXEC -> (MEM) -> WB by an internal FSM.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   rg_wr_en .. imm_in    control set from the external decoder (stable DECODE..WB)
//   instruction, pc_out   IR contents and current PC
//   state                 FSM state (FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4)
//   mem                   instruction/data memory handshake bus (master side)
//   cycle_cnt,instret_cnt performance counters, built only when DP_PERF_CNT_EN is defined,
//                         otherwise tied to zero
module multicycle_datapath #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rg_wr_en,
  input  logic                 sel_a,
  input  logic                 sel_b,
  input  logic                 wb_sel,
  input  logic                 rd_en,
  input  logic                 wr_en,
  input  logic [2:0]           rd_mask,
  input  logic [3:0]           alu_op,
  input  logic                 pc_sel,
  input  logic [XLEN-1:0]      imm_in,
  output logic [31:0]          instruction,
  output logic [XLEN-1:0]      pc_out,
  output logic [2:0]           state,
  multicycle_datapath_if.master mem,
  output logic [63:0]          cycle_cnt,
  output logic [63:0]          instret_cnt
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned RW  = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     ir_q;
  logic [XLEN-1:0] a_q, b_q, r_q, mdr_q;
  logic [XLEN-1:0] rf [NREGS];

  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [XLEN-1:0] op_a, op_b, alu_res;
  logic [SHW-1:0]  shamt;
  logic            rd_valid;

  assign rs1 = ir_q[19:15];
  assign rs2 = ir_q[24:20];
  assign rd  = ir_q[11:7];
  assign rd_valid = (rd != 5'd0) && (32'(rd) < NREGS);

  // Register file read ports; x0 and out-of-range indices read as zero
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if ((rs1 != 5'd0) && (32'(rs1) < NREGS)) rs1_val = rf[rs1[RW-1:0]];
    if ((rs2 != 5'd0) && (32'(rs2) < NREGS)) rs2_val = rf[rs2[RW-1:0]];
  end

  // ALU
  always_comb begin
    op_a  = sel_a ? pc_q : a_q;
    op_b  = sel_b ? imm_in : b_q;
    shamt = op_b[SHW-1:0];
    case (alu_op)
      4'd0:    alu_res = op_a + op_b;
      4'd1:    alu_res = op_a - op_b;
      4'd2:    alu_res = op_a << shamt;
      4'd3:    alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'd4:    alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      4'd5:    alu_res = op_a ^ op_b;
      4'd6:    alu_res = op_a >> shamt;
      4'd7:    alu_res = $signed(op_a) >>> shamt;
      4'd8:    alu_res = op_a | op_b;
      4'd9:    alu_res = op_a & op_b;
      4'd10:   alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // FSM next state and handshake strobes
  always_comb begin
    state_d      = state_q;
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem.imem_req = 1'b1;
        if (mem.imem_ready) state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = (rd_en || wr_en) ? S_MEM : S_WB;
      S_MEM: begin
        mem.dmem_req = 1'b1;
        mem.dmem_we  = wr_en;
        if (mem.dmem_ready) state_d = S_WB;
      end
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Address/data lines always reflect the latches; only req/we are qualified by state
  assign mem.imem_addr  = pc_q;
  assign mem.dmem_addr  = r_q;
  assign mem.dmem_wdata = b_q;
  assign mem.dmem_mask  = rd_mask;

  // Datapath latches and register file write port
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= XLEN'(RESET_PC);
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      r_q   <= '0;
      mdr_q <= '0;
      for (int unsigned i = 0; i < NREGS; i++) rf[RW'(i)] <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (mem.imem_ready) ir_q <= mem.imem_rdata;
        end
        S_DECODE: begin
          a_q <= rs1_val;
          b_q <= rs2_val;
        end
        S_EXEC: r_q <= alu_res;
        S_MEM: begin
          // A request with both rd_en and wr_en is a store, so MDR is left alone
          if (mem.dmem_ready && rd_en && !wr_en) mdr_q <= mem.dmem_rdata;
        end
        S_WB: begin
          if (rg_wr_en && rd_valid) rf[rd[RW-1:0]] <= wb_sel ? mdr_q : r_q;
          pc_q <= pc_sel ? {r_q[XLEN-1:1], 1'b0} : pc_q + XLEN'(PC_STEP);
        end
        default: ;
      endcase
    end
  end

  assign instruction = ir_q;
  assign pc_out      = pc_q;
  assign state       = state_q;

`ifdef DP_PERF_CNT_EN
  logic [63:0] cycle_q, instret_q;

  // Cycle and retired-instruction counters; retirement is the WB -> FETCH step
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q <= cycle_q + 64'd1;
      if (state_q == S_WB) instret_q <= instret_q + 64'd1;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule
